// File: rtl/scan_decoder_pkg.sv
// Shared mode encodings, FSM state type and the active-low one-hot decode
// used by the scan_decoder block.
package scan_decoder_pkg;

  localparam int unsigned MAX_ADDR_W = 8;
  localparam int unsigned MAX_NOUT   = 1 << MAX_ADDR_W;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_IDLE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN,
    ST_PULSE
  } state_t;

  // Callers size-cast the result down to their own output count.
  function automatic logic [MAX_NOUT-1:0] onehot_n(input logic [MAX_ADDR_W-1:0] idx);
    return ~(MAX_NOUT'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// Loadable down-counter timing SCAN slots and PULSE strobes; terminal marks
// the last cycle of the current hold.
module dwell_counter #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic               terminal
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - DWELL_W'(1);
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/scan_decoder.sv
// Registered ADDR_W-to-2^ADDR_W active-low decoder with DIRECT, SCAN and
// PULSE modes; all outputs are registered so selects are glitch-free.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic                     start,
  output logic [(1<<ADDR_W)-1:0]   O_n,
  output logic [ADDR_W-1:0]        cur_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NOUT = 1 << ADDR_W;

  function automatic logic [NOUT-1:0] dec_n(input logic [ADDR_W-1:0] i);
    return NOUT'(onehot_n(MAX_ADDR_W'(i)));
  endfunction

  state_t state;
  logic   scan_run;
  logic   scan_launch;
  logic   pulse_launch;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_term;

  // The counter is reloaded with the live dwell at every slot start, so a
  // mid-slot dwell change only affects the following slot.
  always_comb begin
    scan_run     = (state == ST_SCAN) && en && (mode == MODE_SCAN);
    scan_launch  = (state == ST_IDLE) && en && (mode == MODE_SCAN);
    pulse_launch = (state == ST_IDLE) && en && (mode == MODE_PULSE) && start;
    cnt_load     = scan_launch || pulse_launch || (scan_run && cnt_term);
    cnt_dec      = (scan_run || ((state == ST_PULSE) && en)) && !cnt_term;
  end

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (dwell),
    .terminal (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      O_n     <= '1;
      cur_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && (mode == MODE_DIRECT)) begin
            state   <= ST_DIRECT;
            O_n     <= dec_n(addr);
            cur_idx <= addr;
          end else if (scan_launch) begin
            state   <= ST_SCAN;
            O_n     <= dec_n('0);
            cur_idx <= '0;
            busy    <= 1'b1;
          end else if (pulse_launch) begin
            // cur_idx doubles as the latched pulse address.
            state   <= ST_PULSE;
            O_n     <= dec_n(addr);
            cur_idx <= addr;
            busy    <= 1'b1;
          end
        end
        ST_DIRECT: begin
          if (en && (mode == MODE_DIRECT)) begin
            O_n     <= dec_n(addr);
            cur_idx <= addr;
          end else begin
            state   <= ST_IDLE;
            O_n     <= '1;
            cur_idx <= '0;
          end
        end
        ST_SCAN: begin
          if (!scan_run) begin
            state   <= ST_IDLE;
            O_n     <= '1;
            cur_idx <= '0;
            busy    <= 1'b0;
          end else if (cnt_term) begin
            O_n     <= dec_n(cur_idx + ADDR_W'(1));
            cur_idx <= cur_idx + ADDR_W'(1);
          end
        end
        ST_PULSE: begin
          if (!en || cnt_term) begin
            state   <= ST_IDLE;
            O_n     <= '1;
            cur_idx <= '0;
            busy    <= 1'b0;
            done    <= en;
          end
        end
        default: begin
          state   <= ST_IDLE;
          O_n     <= '1;
          cur_idx <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder: a 4-output instance for all
// modes and an 8-output instance for the wide SCAN sweep.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, start;
  logic [1:0] mode;
  logic [1:0] addr;
  logic [7:0] dwell;
  logic [3:0] O_n;
  logic [1:0] cur_idx;
  logic       busy, done;

  logic       en8, start8;
  logic [1:0] mode8;
  logic [2:0] addr8;
  logic [3:0] dwell8;
  logic [7:0] O_n8;
  logic [2:0] cur_idx8;
  logic       busy8, done8;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_on = 1'b0;

  logic [3:0] dec_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  scan_decoder #(.ADDR_W(2), .DWELL_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .dwell(dwell),
    .start(start), .O_n(O_n), .cur_idx(cur_idx), .busy(busy), .done(done)
  );

  scan_decoder #(.ADDR_W(3), .DWELL_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .addr(addr8), .dwell(dwell8),
    .start(start8), .O_n(O_n8), .cur_idx(cur_idx8), .busy(busy8), .done(done8)
  );

  // At most one low output on either instance, every cycle after reset.
  always @(negedge clk) begin
    if (mon_on) begin
      n_checks++;
      if ($countones(~O_n) > 1) begin
        n_fail++;
        $display("FAIL onehot4: O_n=%b has more than one low bit", O_n);
      end
      n_checks++;
      if ($countones(~O_n8) > 1) begin
        n_fail++;
        $display("FAIL onehot8: O_n8=%b has more than one low bit", O_n8);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; addr = '0; dwell = '0; start = 1'b0;
    en8 = 1'b0; mode8 = 2'b01; addr8 = '0; dwell8 = '0; start8 = 1'b0;
    tick(); tick();
    n_checks++;
    if (O_n !== 4'b1111 || cur_idx !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4: O_n=%b cur=%0d busy=%b done=%b expected 1111/0/0/0", O_n, cur_idx, busy, done);
    end
    n_checks++;
    if (O_n8 !== 8'hFF || cur_idx8 !== 3'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: O_n8=%b cur=%0d busy=%b done=%b expected ff/0/0/0", O_n8, cur_idx8, busy8, done8);
    end
    rst_n = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_direct;
    en = 1'b1; mode = 2'b00;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      tick();
      n_checks++;
      if (O_n !== dec_tbl[a] || cur_idx !== 2'(a) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL direct a=%0d: O_n=%b cur=%0d busy=%b expected %b/%0d/0", a, O_n, cur_idx, busy, dec_tbl[a], a);
      end
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || cur_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL direct_en0: O_n=%b cur=%0d expected 1111/0", O_n, cur_idx);
    end
    en = 1'b1; addr = 2'd2;
    tick();
    n_checks++;
    if (O_n !== 4'b1011) begin
      n_fail++;
      $display("FAIL direct_reenter: O_n=%b expected 1011", O_n);
    end
    mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (O_n !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL mode11 i=%0d: O_n=%b busy=%b done=%b expected 1111/0/0", i, O_n, busy, done);
      end
    end
  endtask

  task automatic test_scan;
    int slot;
    en = 1'b1; mode = 2'b01; dwell = 8'd2;
    for (int c = 0; c < 14; c++) begin
      tick();
      slot = (c / 3) % 4;
      n_checks++;
      if (O_n !== dec_tbl[slot] || cur_idx !== 2'(slot) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL scan c=%0d: O_n=%b cur=%0d busy=%b expected %b/%0d/1", c, O_n, cur_idx, busy, dec_tbl[slot], slot);
      end
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || busy !== 1'b0 || cur_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL scan_abort: O_n=%b busy=%b cur=%0d expected 1111/0/0", O_n, busy, cur_idx);
    end
  endtask

  task automatic test_pulse;
    en = 1'b1; mode = 2'b10; addr = 2'd3; dwell = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (O_n !== 4'b0111 || busy !== 1'b1 || done !== 1'b0 || cur_idx !== 2'd3) begin
        n_fail++;
        $display("FAIL pulse i=%0d: O_n=%b busy=%b done=%b cur=%0d expected 0111/1/0/3", i, O_n, busy, done, cur_idx);
      end
      if (i == 1) begin
        start = 1'b1; addr = 2'd0;
      end else begin
        start = 1'b0;
      end
    end
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_end: O_n=%b done=%b busy=%b expected 1111/1/0", O_n, done, busy);
    end
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_after: O_n=%b done=%b expected 1111/0", O_n, done);
    end
  endtask

  task automatic test_back_to_back;
    en = 1'b1; mode = 2'b10; addr = 2'd1; dwell = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (O_n !== 4'b1101) begin
        n_fail++;
        $display("FAIL b2b_first i=%0d: O_n=%b expected 1101", i, O_n);
      end
    end
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: O_n=%b done=%b expected 1111/1", O_n, done);
    end
    start = 1'b1; addr = 2'd2;
    tick();
    start = 1'b0; mode = 2'b11;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (O_n !== 4'b1011 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_second i=%0d: O_n=%b busy=%b done=%b expected 1011/1/0", i, O_n, busy, done);
      end
    end
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_end: O_n=%b done=%b expected 1111/1", O_n, done);
    end
    mode = 2'b10; addr = 2'd0; dwell = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (O_n !== 4'b1110) begin
      n_fail++;
      $display("FAIL abort_launch: O_n=%b expected 1110", O_n);
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_abort: O_n=%b busy=%b done=%b expected 1111/0/0", O_n, busy, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_abort_done: done=%b expected 0", done);
    end
  endtask

  task automatic test_reset_mid;
    en = 1'b1; mode = 2'b01; dwell = 8'd2;
    repeat (4) tick();
    n_checks++;
    if (cur_idx !== 2'd1 || O_n !== 4'b1101) begin
      n_fail++;
      $display("FAIL rst_scan_pre: cur=%0d O_n=%b expected 1/1101", cur_idx, O_n);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || cur_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_scan: O_n=%b busy=%b done=%b cur=%0d expected 1111/0/0/0", O_n, busy, done, cur_idx);
    end
    rst_n = 1'b1; en = 1'b0;
    tick();
    en = 1'b1; mode = 2'b10; addr = 2'd2; dwell = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (O_n !== 4'b1011 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pulse_pre: O_n=%b busy=%b expected 1011/1", O_n, busy);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (O_n !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || cur_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_pulse: O_n=%b busy=%b done=%b cur=%0d expected 1111/0/0/0", O_n, busy, done, cur_idx);
    end
    rst_n = 1'b1; mode = 2'b11;
    repeat (2) tick();
    n_checks++;
    if (O_n !== 4'b1111 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mode11_after_rst: O_n=%b busy=%b expected 1111/0", O_n, busy);
    end
  endtask

  task automatic test_scan8;
    int slot;
    logic [7:0] exp8;
    en8 = 1'b1; mode8 = 2'b01; dwell8 = 4'd1;
    for (int c = 0; c < 18; c++) begin
      tick();
      slot = (c / 2) % 8;
      exp8 = ~(8'd1 << slot);
      n_checks++;
      if (O_n8 !== exp8 || cur_idx8 !== 3'(slot) || busy8 !== 1'b1) begin
        n_fail++;
        $display("FAIL scan8 c=%0d: O_n8=%b cur=%0d busy=%b expected %b/%0d/1", c, O_n8, cur_idx8, busy8, exp8, slot);
      end
    end
    en8 = 1'b0;
    tick();
    n_checks++;
    if (O_n8 !== 8'hFF || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL scan8_abort: O_n8=%b busy=%b expected 11111111/0", O_n8, busy8);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_pulse();
    test_back_to_back();
    test_reset_mid();
    test_scan8();
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered successor to the 2-to-4 active-low decoder: an ADDR_W-to-2^ADDR_W decoder with active-low one-hot outputs, an enable, and three operating modes. The modes are direct (registered decode), scan (auto-cycling through every output with a programmable dwell) and pulse (one-shot timed strobe of a selected output). It drives chip-select and row-strobe lines in the lab designs, replacing the combinational decoder wherever glitch-free or timed selects are required.

## Interface
Parameters:
- ADDR_W, 2, address width; output count NOUT = 2^ADDR_W (ADDR_W ≥ 1)
- DWELL_W, 8, width of dwell count; each selected output is held low for dwell+1 cycles

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- en  in  1  enable; when 0, all outputs deassert (high) and any scan/pulse is aborted
- mode  in  2  00 DIRECT, 01 SCAN, 10 PULSE, 11 reserved (treated as idle)
- addr  in  ADDR_W  select index for DIRECT and PULSE
- dwell  in  DWELL_W  hold length minus one for SCAN/PULSE
- start  in  1  single-cycle request to launch a PULSE
- O_n  out  NOUT  active-low one-hot outputs; at most one bit low at any time
- cur_idx  out  ADDR_W  index of the currently asserted output (0 when none)
- busy  out  1  high while a SCAN or PULSE is in progress
- done  out  1  one-cycle pulse at end of a PULSE

## Operation
- Reset values: O_n = all ones, cur_idx = 0, busy = 0, done = 0, FSM = IDLE, dwell counter = 0.
- FSM states: IDLE, DIRECT, SCAN, PULSE.
- IDLE: O_n all ones. With en = 1: mode 00 → DIRECT; mode 01 → SCAN, starting at index 0; mode 10 with start = 1 → PULSE on addr. Mode 11 or en = 0 → stay IDLE.
- DIRECT: each cycle O_n ← ~(1 << addr), cur_idx ← addr. Leaving when en = 0 or mode ≠ 00 → IDLE, O_n all ones on the next edge.
- SCAN: the output at cur_idx is held low for dwell+1 cycles, then cur_idx increments modulo NOUT (NOUT−1 wraps to 0), with no gap cycle between slots. dwell is sampled at the start of each slot; changes mid-slot take effect at the next slot. busy = 1 throughout. Exit on en = 0 or mode ≠ 01 → IDLE, outputs high on the next edge, and the partial slot is discarded.
- PULSE: addr and dwell are latched on the launch cycle, and output addr is held low for dwell+1 cycles. On the final cycle's edge: O_n → all ones, done = 1 for one cycle, state → IDLE. start during PULSE is ignored. en = 0 aborts: outputs high, no done pulse. A mode change during PULSE does not abort it.
- PULSE re-launch: the earliest re-launch is a start in the cycle done is high. That cycle is in IDLE, so the new pulse's outputs go low on the next edge. This gives exactly one idle (all-high) cycle between back-to-back pulses.
- Reset mid-operation: rst_n = 0 forces reset values on that edge, regardless of state.
- Invariant: O_n has at most one zero bit on every cycle; no state produces two low outputs.

## Timing
- DIRECT latency: addr/en change → O_n change on the next rising edge (1 cycle).
- SCAN: first output low 1 cycle after entry; full sweep period = NOUT × (dwell+1) cycles.
- PULSE: O_n[addr] low from edge k+1 to edge k+1+dwell inclusive, where start is sampled at edge k. done is high at edge k+2+dwell, the same edge O_n returns high.
- Abort/exit: all outputs high exactly 1 cycle after the en/mode condition is sampled.

## Structure
- Package scan_decoder_pkg holds the mode encoding constants (MODE_DIRECT, MODE_SCAN, MODE_PULSE, MODE_IDLE) and the state enum typedef.
- One sub-module, dwell_counter, of width DWELL_W. It has load/enable inputs and a terminal flag, and is shared by SCAN and PULSE.
- The one-hot decode is a function in the package, ~(1 << idx), width NOUT.

## Test plan
- Exhaustive DIRECT, ADDR_W = 2: en = 1, addr 0..3 → O_n = 1110, 1101, 1011, 0111 one cycle later. en = 0 → 1111.
- SCAN, ADDR_W = 2, dwell = 2: O_n cycles 1110, 1101, 1011, 0111 with 3 cycles each, wrapping to 1110 after 12 cycles. Drop en mid-slot → 1111 next cycle, busy = 0.
- PULSE, addr = 3, dwell = 4: O_n = 0111 for exactly 5 cycles; done high on the cycle O_n returns to 1111. A start during the pulse has no effect.
- Back-to-back PULSE: start asserted on the done cycle → exactly one 1111 cycle between pulses.
- rst_n = 0 mid-SCAN and mid-PULSE: next edge gives O_n = 1111, busy = 0, done = 0, cur_idx = 0. mode = 11 with en = 1 stays at 1111.
- ADDR_W = 3, DWELL_W = 4: SCAN sweeps all 8 outputs with wrap 7→0. The one-hot checker never sees two low bits across all modes.
